// File: rtl/axis_data_chk_if.sv
// AXI-Stream bundle between the stream source and axis_data_chk.
// master drives tdata/tvalid/tuser/tkeep/tlast, slave drives tready.
interface axis_data_chk_if #(
  parameter int G_AXIS_DATA_WIDTH = 1024
) ();
  logic [G_AXIS_DATA_WIDTH-1:0]   tdata;
  logic                           tvalid;
  logic                           tuser;
  logic [G_AXIS_DATA_WIDTH/8-1:0] tkeep;
  logic                           tlast;
  logic                           tready;

  modport master (
    output tdata, tvalid, tuser, tkeep, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tuser, tkeep, tlast,
    output tready
  );
endinterface

// File: rtl/axis_data_chk.sv
// AXI-Stream sink/checker: length, tkeep, tuser, 64-bit lane index pattern.
// Ports: clk/rst_n, enable, clear, pkt_length, rx slave bundle, sat. counters,
// chk_busy. Macro AXIS_DATA_CHK_BP_EN: LFSR-driven tready backpressure.
module axis_data_chk #(
  parameter int G_AXIS_DATA_WIDTH = 1024,
  parameter int CNT_WIDTH         = 32
) (
  input  logic                 axis_streaming_data_clk,
  input  logic                 axis_streaming_rst_n,
  input  logic                 axis_data_chk_enable,
  input  logic                 axis_data_chk_clear,
  input  logic [15:0]          pkt_length,
  axis_data_chk_if.slave       axis_streaming_data_rx,
  output logic [CNT_WIDTH-1:0] pkt_count,
  output logic [CNT_WIDTH-1:0] beat_count,
  output logic [CNT_WIDTH-1:0] err_len_count,
  output logic [CNT_WIDTH-1:0] err_data_count,
  output logic [CNT_WIDTH-1:0] err_keep_count,
  output logic [CNT_WIDTH-1:0] err_user_count,
  output logic                 chk_busy
);

  localparam int NL = G_AXIS_DATA_WIDTH / 64;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_SOP,
    S_IN_PKT,
    S_DRAIN
  } state_e;

  typedef struct packed {
    logic user;
    logic keep;
    logic data;
    logic len;
    logic beat;
    logic pkt;
  } ev_t;

  state_e      state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [63:0] exp_q, exp_d;
  logic        sync_q, sync_d;
  logic        perr_q, perr_d;
  ev_t         ev_q, ev_d;

  logic [5:0]                cnt_ev;
  logic [5:0][CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic        rdy, acc, last;
  logic        lane_mis;
  logic        b_data, b_keep, b_user, b_err;
  logic [63:0] lane0;
  logic [15:0] idx_inc;
  logic        len_hit, len_ok;

`ifdef AXIS_DATA_CHK_BP_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  // x^16+x^14+x^13+x^11+1, free-running
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13]
                 ^ lfsr_q[12] ^ lfsr_q[10];

  always_ff @(posedge axis_streaming_data_clk
              or negedge axis_streaming_rst_n) begin
    if (!axis_streaming_rst_n) lfsr_q <= 16'hACE1;
    else lfsr_q <= {lfsr_q[14:0], lfsr_fb};
  end

  assign rdy = (state_q != S_IDLE) & lfsr_q[0];
`else
  assign rdy = (state_q != S_IDLE);
`endif

  assign axis_streaming_data_rx.tready = rdy;

  assign acc   = axis_streaming_data_rx.tvalid & rdy;
  assign last  = axis_streaming_data_rx.tlast;
  assign lane0 = axis_streaming_data_rx.tdata[63:0];

  always_comb begin
    lane_mis = 1'b0;
    for (int i = 0; i < NL; i++) begin
      if (axis_streaming_data_rx.tdata[i*64 +: 64] != exp_q)
        lane_mis = 1'b1;
    end
  end

  // First beat after IDLE only seeds; it is never a data error
  assign b_data = acc & sync_q & lane_mis;
  assign b_keep = acc & (axis_streaming_data_rx.tkeep != '1);
  assign b_user = acc & axis_streaming_data_rx.tuser;
  assign b_err  = b_data | b_keep | b_user;

  // idx_q is 0 in WAIT_SOP, so single-beat packets use the same test
  assign idx_inc = idx_q + 16'd1;
  assign len_ok  = (pkt_length == 16'd0) || (idx_inc == pkt_length);
  assign len_hit = (pkt_length != 16'd0) && (idx_inc == pkt_length);

  always_comb begin
    sync_d = sync_q;
    exp_d  = exp_q;
    if (state_q == S_IDLE) sync_d = 1'b0;
    if (acc) begin
      sync_d = 1'b1;
      if (!sync_q || lane_mis) exp_d = lane0 + 64'd1;
      else exp_d = exp_q + 64'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    perr_d   = perr_q;
    ev_d     = '0;
    ev_d.beat = acc;
    ev_d.data = b_data;
    ev_d.keep = b_keep;
    ev_d.user = b_user;
    unique case (state_q)
      S_IDLE: begin
        idx_d  = '0;
        perr_d = 1'b0;
        if (axis_data_chk_enable) state_d = S_WAIT_SOP;
      end
      S_WAIT_SOP, S_IN_PKT: begin
        if (acc) begin
          if (last) begin
            if (len_ok) ev_d.pkt = ~(perr_q | b_err);
            else ev_d.len = 1'b1;
            idx_d   = '0;
            perr_d  = 1'b0;
            state_d = axis_data_chk_enable ? S_WAIT_SOP : S_IDLE;
          end else if (len_hit) begin
            ev_d.len = 1'b1;
            perr_d   = 1'b0;
            state_d  = S_DRAIN;
          end else begin
            idx_d   = idx_inc;
            perr_d  = perr_q | b_err;
            state_d = S_IN_PKT;
          end
        end else if (state_q == S_WAIT_SOP &&
                     !axis_data_chk_enable) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (acc && last) begin
          idx_d   = '0;
          perr_d  = 1'b0;
          state_d = axis_data_chk_enable ? S_WAIT_SOP : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // clear also drops events still in flight
    if (axis_data_chk_clear) ev_d = '0;
  end

  always_ff @(posedge axis_streaming_data_clk
              or negedge axis_streaming_rst_n) begin
    if (!axis_streaming_rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      exp_q   <= '0;
      sync_q  <= 1'b0;
      perr_q  <= 1'b0;
      ev_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      exp_q   <= exp_d;
      sync_q  <= sync_d;
      perr_q  <= perr_d;
      ev_q    <= ev_d;
    end
  end

  assign cnt_ev = ev_q;

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < 6; i++) begin
      if (cnt_ev[i] && cnt_q[i] != '1)
        cnt_d[i] = cnt_q[i] + 1'b1;
    end
    if (axis_data_chk_clear) cnt_d = '0;
  end

  always_ff @(posedge axis_streaming_data_clk
              or negedge axis_streaming_rst_n) begin
    if (!axis_streaming_rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end

  assign pkt_count      = cnt_q[0];
  assign beat_count     = cnt_q[1];
  assign err_len_count  = cnt_q[2];
  assign err_data_count = cnt_q[3];
  assign err_keep_count = cnt_q[4];
  assign err_user_count = cnt_q[5];

  assign chk_busy = (state_q == S_IN_PKT) || (state_q == S_DRAIN);

endmodule
